// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding request between execute and the memory port.
// Checks alignment, drives the memory strobes and returns one response per request.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request; memory outputs hold last values
// ACCESS | address presented; store strobe asserted for this cycle
// WAIT   | load in flight; counting down the memory read latency
// RESP   | one-cycle response pulse, then back to IDLE
module load_store_unit #(
    parameter int XLEN         = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [1:0]      req_width,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic            resp_fault,
    output logic [XLEN-1:0] resp_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [1:0]      mem_wwidth,
    output logic            mem_wenable,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [1:0] WRITE_BYTE     = 2'b00;
    localparam logic [1:0] WRITE_HALFWORD = 2'b01;
    localparam logic [1:0] WRITE_WORD     = 2'b10;

    localparam int CW = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WAIT   = 2'b10,
        RESP   = 2'b11
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              store_q;
    logic [1:0]        width_q;
    logic              unsigned_q;
    logic              fault_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   resp_rdata_q;
    logic [XLEN-1:0]   mem_addr_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic [1:0]        mem_wwidth_q;
    logic              req_fault;
    logic              accept;
    logic              sample;
    logic [XLEN-1:0]   load_ext;
    logic [1:0]        req_wwidth;

    assign req_fault = (req_width == 2'b11)
                     | ((req_width == 2'b01) && req_addr[0])
                     | ((req_width == 2'b10) && (req_addr[1:0] != 2'b00));

    assign accept = req_valid && (state_q == IDLE);
    assign sample = (state_q == WAIT) && (cnt_q == CW'(1));

    always_comb begin
        case (req_width)
            2'b00:   req_wwidth = WRITE_BYTE;
            2'b01:   req_wwidth = WRITE_HALFWORD;
            default: req_wwidth = WRITE_WORD;
        endcase
    end

    always_comb begin
        case (width_q)
            2'b00:   load_ext = {{(XLEN-8){~unsigned_q & mem_rdata[7]}}, mem_rdata[7:0]};
            2'b01:   load_ext = {{(XLEN-16){~unsigned_q & mem_rdata[15]}}, mem_rdata[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_fault  = 1'b0;
        mem_wenable = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_fault ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                // Strobe gated by reset so an abort in this cycle never writes.
                mem_wenable = store_q & reset;
                state_d     = store_q ? RESP : WAIT;
            end
            WAIT: begin
                if (sample) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            store_q      <= 1'b0;
            width_q      <= 2'b00;
            unsigned_q   <= 1'b0;
            fault_q      <= 1'b0;
            cnt_q        <= '0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wwidth_q <= WRITE_WORD;
        end else begin
            if (accept) begin
                store_q      <= req_store;
                width_q      <= req_width;
                unsigned_q   <= req_unsigned;
                fault_q      <= req_fault;
                resp_rdata_q <= '0;
                if (!req_fault) begin
                    mem_addr_q <= req_addr;
                    if (req_store) begin
                        mem_wdata_q  <= req_wdata;
                        mem_wwidth_q <= req_wwidth;
                    end
                end
            end
            if ((state_q == ACCESS) && !store_q) begin
                cnt_q <= CW'(READ_LATENCY);
            end
            if (state_q == WAIT) begin
                if (sample) begin
                    resp_rdata_q <= load_ext;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end
    end

    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wwidth = mem_wwidth_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-array memory with one-cycle read latency,
// scoreboard queues for responses and writes, checked on the falling edge.
module tb_load_store_unit;

    localparam int XLEN = 32;
    localparam int RL   = 1;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_store = 1'b0;
    logic [1:0]      req_width = 2'b00;
    logic            req_unsigned = 1'b0;
    logic [XLEN-1:0] req_addr = '0;
    logic [XLEN-1:0] req_wdata = '0;
    logic            resp_valid;
    logic            resp_fault;
    logic [XLEN-1:0] resp_rdata;
    logic [XLEN-1:0] mem_addr;
    logic [1:0]      mem_wwidth;
    logic            mem_wenable;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    load_store_unit #(.XLEN(XLEN), .READ_LATENCY(RL)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_width    (req_width),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_fault   (resp_fault),
        .resp_rdata   (resp_rdata),
        .mem_addr     (mem_addr),
        .mem_wwidth   (mem_wwidth),
        .mem_wenable  (mem_wenable),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Memory block: synchronous read, bytes addr..addr+3 little-endian.
    logic [7:0]  mem [0:4095];
    logic [11:0] a0, a1, a2, a3;
    assign a0 = mem_addr[11:0];
    assign a1 = a0 + 12'd1;
    assign a2 = a0 + 12'd2;
    assign a3 = a0 + 12'd3;

    always @(posedge clock) begin
        if (mem_wenable) begin
            mem[a0] <= mem_wdata[7:0];
            if (mem_wwidth != 2'b00) mem[a1] <= mem_wdata[15:8];
            if (mem_wwidth == 2'b10) begin
                mem[a2] <= mem_wdata[23:16];
                mem[a3] <= mem_wdata[31:24];
            end
        end
        mem_rdata <= {mem[a3], mem[a2], mem[a1], mem[a0]};
    end

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          due;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  width;
        logic [31:0] data;
        int          due;
    } wr_t;

    typedef struct {
        logic        st;
        logic [1:0]  w;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;

    resp_t      rq[$];
    wr_t        wq[$];
    logic [7:0] ref_mem [0:4095];
    req_t       pat [7];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic model_fault(input logic [1:0] w, input logic [31:0] a);
        return (w == 2'b11) || (w == 2'b01 && a[0]) || (w == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_load(input logic [11:0] a, input logic [1:0] w,
                                               input logic u);
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [31:0] r;
        b0 = ref_mem[a];
        b1 = ref_mem[a + 12'd1];
        if (w == 2'b00)
            r = u ? {24'h0, b0} : {{24{b0[7]}}, b0};
        else if (w == 2'b01)
            r = u ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
        else
            r = {ref_mem[a + 12'd3], ref_mem[a + 12'd2], b1, b0};
        return r;
    endfunction

    // Called in the cycle before the accepting edge; records what must come back.
    task automatic accept_push(input logic st, input logic [1:0] w, input logic u,
                               input logic [31:0] a, input logic [31:0] d);
        resp_t r;
        wr_t   x;
        int    acc;
        acc     = cyc + 1;
        r.fault = model_fault(w, a);
        r.rdata = (r.fault || st) ? 32'h0 : model_load(a[11:0], w, u);
        r.due   = r.fault ? acc : (st ? acc + 1 : acc + 1 + RL);
        rq.push_back(r);
        if (!r.fault && st) begin
            x.addr = a; x.width = w; x.data = d; x.due = acc;
            wq.push_back(x);
            ref_mem[a[11:0]] = d[7:0];
            if (w != 2'b00) ref_mem[a[11:0] + 12'd1] = d[15:8];
            if (w == 2'b10) begin
                ref_mem[a[11:0] + 12'd2] = d[23:16];
                ref_mem[a[11:0] + 12'd3] = d[31:24];
            end
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        @(negedge clock);
        while (!req_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        chk("ready_timeout", req_ready, 1'b1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((rq.size() != 0 || wq.size() != 0) && t < 50) begin
            @(negedge clock);
            t++;
        end
        chk("drain_timeout", rq.size() + wq.size(), 0);
    endtask

    task automatic drive(input logic st, input logic [1:0] w, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_store = st; req_width = w;
        req_unsigned = u; req_addr = a; req_wdata = d;
    endtask

    task automatic issue(input logic st, input logic [1:0] w, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        wait_ready();
        drive(st, w, u, a, d);
        accept_push(st, w, u, a, d);
        @(negedge clock);
        req_valid = 1'b0;
        wait_idle();
    endtask

    task automatic scramble();
        req_store    = 1'($urandom);
        req_width    = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = 32'h0B00 | $urandom_range(0, 255);
        req_wdata    = $urandom;
    endtask

    // Scoreboard side: responses and write strobes compared against the queues.
    initial forever begin
        resp_t r;
        wr_t   x;
        @(negedge clock);
        if (resp_valid) begin
            chk("resp_expected", rq.size() != 0, 1'b1);
            if (rq.size() != 0) begin
                r = rq.pop_front();
                chk("resp_fault", resp_fault, r.fault);
                chk("resp_rdata", resp_rdata, r.rdata);
                chk("resp_cycle", cyc, r.due);
            end
        end
        if (rq.size() != 0 && cyc > rq[0].due) begin
            chk("resp_missing", cyc, rq[0].due);
            void'(rq.pop_front());
        end
        if (mem_wenable) begin
            chk("write_expected", wq.size() != 0, 1'b1);
            if (wq.size() != 0) begin
                x = wq.pop_front();
                chk("write_addr", mem_addr, x.addr);
                chk("write_width", mem_wwidth, x.width);
                chk("write_data", mem_wdata, x.data);
                chk("write_cycle", cyc, x.due);
            end
        end
        if (wq.size() != 0 && cyc > wq[0].due) begin
            chk("write_missing", cyc, wq[0].due);
            void'(wq.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        pat[0] = '{1'b1, 2'b10, 1'b0, 32'h0900, 32'hCAFEF00D};
        pat[1] = '{1'b0, 2'b00, 1'b1, 32'h0901, 32'h0};
        pat[2] = '{1'b1, 2'b00, 1'b0, 32'h0902, 32'h0000007F};
        pat[3] = '{1'b0, 2'b01, 1'b0, 32'h0902, 32'h0};
        pat[4] = '{1'b0, 2'b10, 1'b0, 32'h0900, 32'h0};
        pat[5] = '{1'b1, 2'b01, 1'b0, 32'h0903, 32'h1};
        pat[6] = '{1'b0, 2'b01, 1'b1, 32'h0900, 32'h0};

        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_fault", resp_fault, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wwidth", mem_wwidth, 2'b10);
        chk("rst_mem_wenable", mem_wenable, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        reset = 1'b1;

        issue(1'b1, 2'b10, 1'b0, 32'h0800, 32'hDEADBEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h0800, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 32'h0803, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 32'h0803, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h0802, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h0800, 32'hFFFF1234);
        issue(1'b0, 2'b10, 1'b0, 32'h0800, 32'h0);

        // Faulting requests: no memory traffic, immediate response.
        issue(1'b0, 2'b10, 1'b0, 32'h0802, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h0801, 32'h00005555);
        issue(1'b1, 2'b11, 1'b0, 32'h0800, 32'h12345678);
        issue(1'b0, 2'b11, 1'b1, 32'h0800, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h0800, 32'h0);

        // Back-to-back with req_valid held high and fields changing while busy.
        wait_ready();
        req_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            int t = 0;
            int due;
            while (!req_ready && t < 50) begin
                scramble();
                @(negedge clock);
                t++;
            end
            chk("hold_ready", req_ready, 1'b1);
            drive(pat[k].st, pat[k].w, pat[k].u, pat[k].a, pat[k].d);
            accept_push(pat[k].st, pat[k].w, pat[k].u, pat[k].a, pat[k].d);
            due = rq[rq.size() - 1].due;
            @(negedge clock);
            while (cyc <= due && t < 50) begin
                chk("hold_busy_ready", req_ready, 1'b0);
                scramble();
                @(negedge clock);
                t++;
            end
        end
        req_valid = 1'b0;
        wait_idle();

        // Reset during the ACCESS cycle of a store.
        issue(1'b1, 2'b10, 1'b0, 32'h0A00, 32'h11223344);
        wait_ready();
        drive(1'b1, 2'b00, 1'b0, 32'h0A00, 32'h000000AA);
        @(posedge clock);
        #2;
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        chk("abort_st_wenable", mem_wenable, 1'b0);
        chk("abort_st_resp", resp_valid, 1'b0);
        @(negedge clock);
        chk("abort_st_ready", req_ready, 1'b1);
        chk("abort_st_resp2", resp_valid, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Reset during the WAIT cycle of a load.
        wait_ready();
        drive(1'b0, 2'b10, 1'b0, 32'h0A00, 32'h0);
        @(posedge clock);
        #2;
        req_valid = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(negedge clock);
        chk("abort_ld_wenable", mem_wenable, 1'b0);
        chk("abort_ld_resp", resp_valid, 1'b0);
        @(negedge clock);
        chk("abort_ld_ready", req_ready, 1'b1);
        chk("abort_ld_resp2", resp_valid, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Aborted byte store must not have reached memory.
        issue(1'b0, 2'b10, 1'b0, 32'h0A00, 32'h0);

        wait_idle();
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
